if_id_queue: RTL and testbench

Parametrised IF/ID pipeline boundary that replaces the single-entry IF/ID register with a DEPTH-entry in-order instruction queue. Fetch pushes (pc, inst) pairs under a valid/ready handshake. Decode pops the head under its own handshake. A flush input discards all queued instructions on redirect (branch/jump), and the queue decouples fetch from decode stalls.

---
 rtl/if_id_queue_pkg.sv | 10 +
 rtl/if_id_queue.sv | 86 ++++++++
 tb/tb_if_id_queue.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/if_id_queue_pkg.sv
// Shared constants for the IF/ID instruction queue: bus widths, reset level and default depth.
package if_id_queue_pkg;

  localparam logic RST_ENABLE      = 1'b1;
  localparam int   INST_ADDR_BUS_W = 32;
  localparam int   INST_BUS_W      = 32;
  localparam logic [INST_BUS_W-1:0] ZERO_WORD = '0;
  localparam int   IF_ID_DEPTH     = 4;

endpackage

// File: rtl/if_id_queue.sv
// IF/ID boundary as a DEPTH-entry in-order queue of {pc, inst} pairs.
// Fetch pushes, decode pops the head, and flush empties it on redirect.
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int ADDR_W = INST_ADDR_BUS_W,
  parameter int INST_W = INST_BUS_W,
  parameter int DEPTH  = IF_ID_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         if_valid,
  input  logic [ADDR_W-1:0]            if_pc,
  input  logic [INST_W-1:0]            if_inst,
  output logic                         if_ready,
  output logic                         id_valid,
  output logic [ADDR_W-1:0]            id_pc,
  output logic [INST_W-1:0]            id_inst,
  input  logic                         id_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int ENTRY_W = ADDR_W + INST_W;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               full, empty, push, pop;
  logic [ENTRY_W-1:0] head;

  // if_ready comes only from registered occupancy, never from id_ready.
  assign full     = (cnt_q == FULL_CNT);
  assign empty    = (cnt_q == '0);
  assign if_ready = !full;
  assign id_valid = !empty;
  assign count    = cnt_q;

  assign push = if_valid && !full && !flush;
  assign pop  = id_ready && !empty && !flush;

  assign head    = mem_q[rd_ptr_q];
  assign id_pc   = empty ? '0 : head[ENTRY_W-1 -: ADDR_W];
  assign id_inst = empty ? '0 : head[INST_W-1:0];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: empty gating hides stale words.
  always_ff @(posedge clk) begin
    if (push && rst != RST_ENABLE) mem_q[wr_ptr_q] <= {if_pc, if_inst};
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue (DEPTH=4) with a queue-based reference model checked every cycle.
module tb_if_id_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, flush, if_valid, id_ready;
  logic [31:0] if_pc, if_inst;
  logic        if_ready, id_valid;
  logic [31:0] id_pc, id_inst;
  logic [2:0]  count;

  int errors = 0;
  int checks = 0;

  logic [63:0] model_q [$];
  bit          model_ok = 1'b0;
  logic [31:0] seen [$];

  if_id_queue #(.ADDR_W(32), .INST_W(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst), .if_ready(if_ready),
    .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst), .id_ready(id_ready),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: a plain queue; acceptance is decided from occupancy before the edge.
  always @(posedge clk) begin
    if (rst || flush) begin
      model_q.delete();
      if (rst) model_ok = 1'b1;
    end else begin
      automatic bit do_push = if_valid && (model_q.size() < DEPTH);
      automatic bit do_pop  = id_ready && (model_q.size() > 0);
      if (do_pop)  void'(model_q.pop_front());
      if (do_push) model_q.push_back({if_pc, if_inst});
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      automatic int n = model_q.size();
      chk("m_count",    64'(count),    64'(n));
      chk("m_if_ready", 64'(if_ready), 64'(n < DEPTH));
      chk("m_id_valid", 64'(id_valid), 64'(n > 0));
      chk("m_id_pc",    64'(id_pc),    (n > 0) ? 64'(model_q[0][63:32]) : 64'd0);
      chk("m_id_inst",  64'(id_inst),  (n > 0) ? 64'(model_q[0][31:0])  : 64'd0);
    end
  end

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc + 32'h13;
  endfunction

  // Apply inputs, record the head decode will take at this edge, then advance past the edge.
  task automatic drive(input logic r, input logic f, input logic v, input logic [31:0] pc,
                       input logic rdy);
    rst = r; flush = f; if_valid = v; if_pc = pc; if_inst = inst_of(pc); id_ready = rdy;
    if (!r && !f && rdy && id_valid === 1'b1) seen.push_back(id_pc);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_seen(input string name, input logic [31:0] exp [$]);
    chk({name, "_len"}, 64'(seen.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size() && i < seen.size(); i++)
      chk($sformatf("%s_%0d", name, i), 64'(seen[i]), 64'(exp[i]));
    seen.delete();
  endtask

  initial begin
    logic [31:0] exp [$];
    rst = 1'b1; flush = 1'b0; if_valid = 1'b1; if_pc = 32'h99; if_inst = 32'h1; id_ready = 1'b0;

    // Reset held two cycles with if_valid high
    drive(1, 0, 1, 32'h99, 0);
    drive(1, 0, 1, 32'h99, 0);
    chk("rst_if_ready", 64'(if_ready), 64'd1);
    chk("rst_id_valid", 64'(id_valid), 64'd0);
    chk("rst_id_pc",    64'(id_pc),    64'd0);
    chk("rst_id_inst",  64'(id_inst),  64'd0);
    chk("rst_count",    64'(count),    64'd0);

    // Single pass-through
    drive(0, 0, 1, 32'h1000, 1);
    chk("pt_valid", 64'(id_valid), 64'd1);
    chk("pt_pc",    64'(id_pc),    64'h1000);
    chk("pt_inst",  64'(id_inst),  64'h1013);
    drive(0, 0, 0, 32'h0, 1);
    chk("pt_valid2", 64'(id_valid), 64'd0);
    chk("pt_pc2",    64'(id_pc),    64'd0);
    seen.delete();

    // Fill and stall
    for (int i = 0; i < 4; i++) drive(0, 0, 1, 32'(4 * i), 0);
    chk("fill_count", 64'(count),    64'd4);
    chk("fill_ready", 64'(if_ready), 64'd0);
    drive(0, 0, 1, 32'h10, 0);
    chk("fill_refused", 64'(count), 64'd4);
    drive(0, 0, 1, 32'h10, 1);
    chk("full_pop_count", 64'(count), 64'd3);
    drive(0, 0, 1, 32'h10, 1);
    chk("push_pop_count", 64'(count), 64'd3);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 32'h0, 1);
    chk("drain_count", 64'(count), 64'd0);
    exp = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
    chk_seen("fill_order", exp);

    // Continuous push+pop across pointer wrap
    for (int k = 0; k < 10; k++) begin
      drive(0, 0, 1, 32'(4 * k), 1);
      chk($sformatf("wrap_count_%0d", k), 64'(count), 64'd1);
    end
    drive(0, 0, 0, 32'h0, 1);
    exp.delete();
    for (int k = 0; k < 10; k++) exp.push_back(32'(4 * k));
    chk_seen("wrap_order", exp);

    // Flush with same-cycle push and pop
    drive(0, 0, 1, 32'h100, 0);
    drive(0, 0, 1, 32'h104, 0);
    drive(0, 0, 1, 32'h108, 0);
    chk("pre_flush_count", 64'(count), 64'd3);
    drive(0, 1, 1, 32'h200, 1);
    chk("flush_count", 64'(count),    64'd0);
    chk("flush_valid", 64'(id_valid), 64'd0);
    drive(0, 0, 1, 32'h300, 0);
    chk("post_flush_pc",    64'(id_pc),   64'h300);
    chk("post_flush_count", 64'(count),   64'd1);
    drive(0, 0, 0, 32'h0, 1);
    drive(0, 0, 0, 32'h0, 1);
    exp = '{32'h300};
    chk_seen("flush_order", exp);

    // Full with simultaneous pop, then the held push goes in
    for (int i = 0; i < 4; i++) drive(0, 0, 1, 32'h400 + 32'(4 * i), 0);
    drive(0, 0, 1, 32'h410, 1);
    chk("fp_count", 64'(count), 64'd3);
    chk("fp_head",  64'(id_pc), 64'h404);
    drive(0, 0, 1, 32'h410, 0);
    chk("fp_count2", 64'(count),    64'd4);
    chk("fp_ready2", 64'(if_ready), 64'd0);

    // Reset mid-operation discards contents
    drive(1, 0, 1, 32'h500, 1);
    chk("midrst_count", 64'(count),    64'd0);
    chk("midrst_valid", 64'(id_valid), 64'd0);
    drive(0, 0, 0, 32'h0, 0);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
